// File: rtl/aclint_multi_if.sv
// aclint_multi_if: Membus request/response bundle (valid/ready/wen/addr/wdata/wmask -> rvalid/rdata), master and slave modports
interface aclint_multi_if;
  logic        valid;
  logic        ready;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rvalid;
  logic [63:0] rdata;
  modport master (output valid, wen, addr, wdata, wmask, input ready, rvalid, rdata);
  modport slave (input valid, wen, addr, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/aclint_multi.sv
// aclint_multi: multi-hart ACLINT (shared mtime + prescaler, per-hart MSIP/MTIMECMP/SETSSIP); ports clk, rst (async active-low), membus slave, msip/mtip/setssip per hart, mtime
module aclint_multi #(
  parameter int unsigned NUM_HARTS = 4,
  parameter logic [63:0] BASE = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  aclint_multi_if.slave        membus,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] setssip,
  output logic [63:0]          mtime
);
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
  logic [NUM_HARTS-1:0] msip_q, msip_d, setssip_q, setssip_d;
  logic [63:0] cmp_q [NUM_HARTS];
  logic [63:0] cmp_d [NUM_HARTS];
  logic [63:0] mtime_q, mtime_d, rdata_q, rdata_d, rd_val, m;
  logic [15:0] presc_q, presc_d;
  logic rvalid_q, rvalid_d, blk, req_wr, req_rd, tick;
  logic sel_msip, sel_cmp, sel_mtime, sel_ssip;
  logic [10:0] idx;
  logic unused_addr;
  assign unused_addr = ^membus.addr[2:0];
  assign membus.ready = 1'b1;
  assign membus.rvalid = rvalid_q;
  assign membus.rdata = rdata_q;
  assign msip = msip_q;
  assign setssip = setssip_q;
  assign mtime = mtime_q;
  always_comb begin
    blk = membus.valid && membus.addr[63:16] == BASE[63:16];
    req_wr = blk && membus.wen;
    req_rd = membus.valid && !membus.wen;
    idx = membus.addr[13:3];
    sel_msip = blk && membus.addr[15:14] == 2'b00;
    sel_cmp = blk && membus.addr[15:14] == 2'b01;
    sel_mtime = blk && membus.addr[15:3] == 13'h17FF;
    sel_ssip = blk && membus.addr[15:14] == 2'b11;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{membus.wmask[b]}};
  end
  always_comb begin
    tick = presc_q == LAST;
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    // an MTIME write overrides the tick and merges with the pre-increment value
    mtime_d = (req_wr && sel_mtime) ? (membus.wdata & m) | (mtime_q & ~m) : mtime_q + {63'd0, tick};
    rd_val = sel_mtime ? mtime_q : 64'd0;
    msip_d = msip_q;
    cmp_d = cmp_q;
    setssip_d = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (idx == 11'(i) && sel_msip && req_wr && membus.wmask[0]) msip_d[i] = membus.wdata[0];
      if (idx == 11'(i) && sel_cmp && req_wr) cmp_d[i] = (membus.wdata & m) | (cmp_q[i] & ~m);
      setssip_d[i] = idx == 11'(i) && sel_ssip && req_wr && membus.wmask[0] && membus.wdata[0];
      if (idx == 11'(i) && sel_msip) rd_val = {63'd0, msip_q[i]};
      if (idx == 11'(i) && sel_cmp) rd_val = cmp_q[i];
    end
    rvalid_d = req_rd;
    rdata_d = req_rd ? rd_val : rdata_q;
  end
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) mtip[i] = mtime_q >= cmp_q[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q <= '0;
      setssip_q <= '0;
      cmp_q <= '{default: '1};
      mtime_q <= '0;
      presc_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      msip_q <= msip_d;
      setssip_q <= setssip_d;
      cmp_q <= cmp_d;
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/aclint_multi.md
# aclint_multi

Parametrised multi-hart ACLINT sitting on the data-side Membus as a memory-mapped slave. Provides one shared 64-bit mtime with a programmable-rate prescaler, per-hart MSIP, per-hart MTIMECMP and per-hart SETSSIP, and drives per-hart interrupt lines to the CSR units.

## Interface
- NUM_HARTS, 4, number of harts; 1..32.
- BASE, 64'h0200_0000, byte base address of the block; must be 64 KiB aligned.
- TICK_DIV, 1, mtime increments once every TICK_DIV clocks; 1..65535.
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- membus  slave  Membus (64-bit data, 8-bit wmask)  register access port.
- msip  output  NUM_HARTS  machine software interrupt pending, one per hart.
- mtip  output  NUM_HARTS  machine timer interrupt pending, one per hart.
- setssip  output  NUM_HARTS  one-cycle supervisor software interrupt set pulse, one per hart.
- mtime  output  64  current mtime value.

## Operation
- Register map (offsets from BASE, 8-byte stride, decode on addr[XLEN-1:3]):
  - 0x0000 + 8*i: MSIP[i], bit 0 only; other bits read 0.
  - 0x4000 + 8*i: MTIMECMP[i], 64 bits.
  - 0xBFF8: MTIME, 64 bits.
  - 0xC000 + 8*i: SETSSIP[i], write-only; reads return 0.
- Hart index i >= NUM_HARTS, or any other offset, is unmapped: writes ignored, reads return 0.
- Writes are byte-masked: new = (wdata & M) | (old & ~M), M = wmask expanded to 64 bits. MSIP uses M[0] only.
- Prescaler: a 16-bit counter counts 0..TICK_DIV-1. When it equals TICK_DIV-1, mtime += 1 (wraps at 2^64 to 0) and the counter returns to 0.
- mtip[i] = (mtime >= mtimecmp[i]), unsigned, combinational from registers.
- msip[i] = MSIP[i] register.
- A write to SETSSIP[i] with wmask[0]=1 and wdata[0]=1 pulses setssip[i] high for exactly one cycle, the cycle after the write is accepted. The write stores nothing.
- Simultaneous events:
  - A write to MTIME in the same cycle as a tick: the written value wins, the increment is dropped, and the prescaler still restarts.
  - A partial-mask MTIME write merges with the pre-increment value.

## Timing
- membus.ready is tied 1: every valid request is accepted in the cycle it is presented.
- Reads:
  - rvalid is asserted exactly one cycle after an accepted read.
  - rdata is registered in the same edge and holds until the next accepted read.
  - rvalid = 0 for writes.
- A register write takes effect at the accepting edge and is visible on outputs (msip, mtip, mtime) the following cycle.
- Back-to-back requests every cycle are supported. A read following a write to the same address returns the written value.
- Reset (asynchronous assert, synchronous-to-clk release):
  - rvalid=0, rdata=0.
  - all MSIP=0, mtime=0, prescaler=0.
  - all MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF, so mtip=0 out of reset.
  - setssip=0.
- Reset mid-transaction discards any pending rvalid and setssip pulse.

## Test plan
- Reset and read-back: release reset with NUM_HARTS=4.
  - Read MTIMECMP[2] -> rdata=64'hFFFF_FFFF_FFFF_FFFF one cycle later, mtip=4'b0000.
  - Read MSIP[3] -> 0.
- Prescaler: TICK_DIV=3, run 30 cycles after reset, read MTIME -> 10 (±1 for read latency). Then write MTIME=64'hFFFF_FFFF_FFFF_FFFF and wait 3 cycles -> mtime=0 (wrap).
- Timer interrupts:
  - Write MTIMECMP[1]=100 with TICK_DIV=1 and mtime=90 -> mtip[1] rises exactly when mtime==100; other mtip bits stay 0.
  - Write MTIMECMP[1]=0xFFFF...F -> mtip[1] falls the next cycle.
- Byte-masked write: MTIMECMP[0]=64'h1122_3344_5566_7788, then write wdata=64'hAAAA_AAAA_AAAA_AAAA with wmask=8'h0F -> read back 64'h1122_3344_AAAA_AAAA.
- Software interrupts:
  - Write MSIP[2]=1 -> msip=4'b0100.
  - Write SETSSIP[3] wdata=1 -> setssip=4'b1000 for exactly one cycle, then 0. Reading SETSSIP[3] returns 0.
- Unmapped and collision:
  - Write MSIP[5] (NUM_HARTS=4) -> no output change; reading it returns 0.
  - Write MTIME=500 on a tick cycle -> read back 500, not 501.
